// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-pipeline definitions: FSM state encoding and reset/bubble constants.
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h8000_0000;

    // A state "owns" the bus while a request is pending or being issued.
    function automatic logic state_issues_req(input fetch_state_t s, input logic redirect);
        logic r;
        r = 1'b0;
        case (s)
            ST_READY: r = !redirect;
            ST_WAIT,
            ST_DROP:  r = 1'b1;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ack bus between the fetch stage and instruction memory.
interface if_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: req/ack fetch FSM, one-entry skid buffer for ID stalls,
// wrong-path drop on redirect, and the IF/ID pipeline register.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR,
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc_in,
    input  logic [31:0]        pcplus_in,
    input  logic               redirect,
    input  logic               id_stall,
    if_fetch_stage_if.master   imem,
    output logic               pc_hold,
    output logic               ifid_valid,
    output logic [31:0]        ifid_instr,
    output logic [31:0]        ifid_pcplus
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  addr_reg, addr_next;
    logic [31:0]  pcp_reg, pcp_next;
    logic [31:0]  skid_instr_reg, skid_instr_next;
    logic [31:0]  skid_pcplus_reg, skid_pcplus_next;
    logic         ifid_valid_next;
    logic [31:0]  ifid_instr_next;
    logic [31:0]  ifid_pcplus_next;

    logic         req_c;
    logic [31:0]  addr_c;
    logic         completion;
    logic [31:0]  req_pcplus;

    assign imem.req  = req_c;
    assign imem.addr = addr_c;

    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        pcp_next         = pcp_reg;
        skid_instr_next  = skid_instr_reg;
        skid_pcplus_next = skid_pcplus_reg;
        ifid_valid_next  = ifid_valid;
        ifid_instr_next  = ifid_instr;
        ifid_pcplus_next = ifid_pcplus;

        req_c  = state_issues_req(state_reg, redirect);
        addr_c = (state_reg == ST_READY) ? pc_in : addr_reg;

        // A zero-wait ack in READY completes with the live PC+4; otherwise the captured one.
        req_pcplus = (state_reg == ST_READY) ? pcplus_in : pcp_reg;
        completion = !redirect && imem.ack &&
                     ((state_reg == ST_READY) || (state_reg == ST_WAIT));

        // The PC advances once per fetched word, and always on redirect to load the target.
        pc_hold = !(completion || redirect);

        if (state_reg == ST_READY) begin
            addr_next = pc_in;
            pcp_next  = pcplus_in;
        end

        if (redirect) begin
            case (state_reg)
                ST_READY: state_next = ST_READY;
                ST_WAIT:  state_next = imem.ack ? ST_READY : ST_DROP;
                ST_HOLD:  state_next = ST_READY;
                ST_DROP:  state_next = imem.ack ? ST_READY : ST_DROP;
                default:  state_next = ST_READY;
            endcase
        end else begin
            case (state_reg)
                ST_READY,
                ST_WAIT: begin
                    if (imem.ack)
                        state_next = id_stall ? ST_HOLD : ST_READY;
                    else
                        state_next = ST_WAIT;
                end
                ST_HOLD:  state_next = id_stall ? ST_HOLD : ST_READY;
                ST_DROP:  state_next = imem.ack ? ST_READY : ST_DROP;
                default:  state_next = ST_READY;
            endcase
        end

        if (redirect) begin
            ifid_valid_next = 1'b0;
            ifid_instr_next = NOP_INSTR;
        end else if (completion) begin
            if (id_stall) begin
                skid_instr_next  = imem.rdata;
                skid_pcplus_next = req_pcplus;
            end else begin
                ifid_valid_next  = 1'b1;
                ifid_instr_next  = imem.rdata;
                ifid_pcplus_next = req_pcplus;
            end
        end else if (state_reg == ST_HOLD && !id_stall) begin
            ifid_valid_next  = 1'b1;
            ifid_instr_next  = skid_instr_reg;
            ifid_pcplus_next = skid_pcplus_reg;
        end else if (!id_stall) begin
            ifid_valid_next = 1'b0;
            ifid_instr_next = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_READY;
            addr_reg        <= RESET_PC;
            pcp_reg         <= 32'h0;
            skid_instr_reg  <= 32'h0;
            skid_pcplus_reg <= 32'h0;
            ifid_valid      <= 1'b0;
            ifid_instr      <= NOP_INSTR;
            ifid_pcplus     <= 32'h0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            pcp_reg         <= pcp_next;
            skid_instr_reg  <= skid_instr_next;
            skid_pcplus_reg <= skid_pcplus_next;
            ifid_valid      <= ifid_valid_next;
            ifid_instr      <= ifid_instr_next;
            ifid_pcplus     <= ifid_pcplus_next;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed table-driven bench for if_fetch_stage plus a reset-mid-fetch sequence.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] pcplus_in;
    logic        redirect;
    logic        id_stall;
    logic        pc_hold;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pcplus;

    if_fetch_stage_if imem_bus();

    if_fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pcplus_in   (pcplus_in),
        .redirect    (redirect),
        .id_stall    (id_stall),
        .imem        (imem_bus),
        .pc_hold     (pc_hold),
        .ifid_valid  (ifid_valid),
        .ifid_instr  (ifid_instr),
        .ifid_pcplus (ifid_pcplus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        redir;
        logic        stall;
        logic [31:0] pc;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_hold;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pcplus;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   failures;

    function automatic vec_t mk(logic rst_n, logic redir, logic stall, logic [31:0] pc,
                                logic ack, logic [31:0] rdata, logic e_req, logic [31:0] e_addr,
                                logic e_hold, logic e_valid, logic [31:0] e_instr,
                                logic [31:0] e_pcplus);
        vec_t v;
        v.rst_n = rst_n;  v.redir = redir;   v.stall = stall;   v.pc = pc;
        v.ack = ack;      v.rdata = rdata;   v.e_req = e_req;   v.e_addr = e_addr;
        v.e_hold = e_hold; v.e_valid = e_valid; v.e_instr = e_instr; v.e_pcplus = e_pcplus;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic redir, input logic stall,
                         input logic [31:0] pc, input logic ack, input logic [31:0] rdata);
        reset          = rst_n;
        redirect       = redir;
        id_stall       = stall;
        pc_in          = pc;
        pcplus_in      = pc + 32'd4;
        imem_bus.ack   = ack;
        imem_bus.rdata = rdata;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 32'h0);

        //           rst redir stall pc            ack rdata          req addr          hold v  instr          pcplus
        // reset, then zero-wait stream of four words
        vecs.push_back(mk(0, 0, 0, 32'h8000_0000, 0, 32'h0,          1, 32'h8000_0000, 1, 0, 32'h0,          32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0000, 1, 32'h2008_0001, 1, 32'h8000_0000, 0, 1, 32'h2008_0001, 32'h8000_0004));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0004, 1, 32'h2008_0002, 1, 32'h8000_0004, 0, 1, 32'h2008_0002, 32'h8000_0008));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0008, 1, 32'h2008_0003, 1, 32'h8000_0008, 0, 1, 32'h2008_0003, 32'h8000_000C));
        vecs.push_back(mk(1, 0, 0, 32'h8000_000C, 1, 32'h2008_0004, 1, 32'h8000_000C, 0, 1, 32'h2008_0004, 32'h8000_0010));
        // three wait states
        vecs.push_back(mk(1, 0, 0, 32'h8000_0010, 0, 32'h0,          1, 32'h8000_0010, 1, 0, 32'h0,          32'h8000_0010));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0010, 0, 32'h0,          1, 32'h8000_0010, 1, 0, 32'h0,          32'h8000_0010));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0010, 0, 32'h0,          1, 32'h8000_0010, 1, 0, 32'h0,          32'h8000_0010));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0010, 1, 32'h2008_0005, 1, 32'h8000_0010, 0, 1, 32'h2008_0005, 32'h8000_0014));
        // id_stall across completion -> HOLD, release
        vecs.push_back(mk(1, 0, 1, 32'h8000_0014, 0, 32'h0,          1, 32'h8000_0014, 1, 1, 32'h2008_0005, 32'h8000_0014));
        vecs.push_back(mk(1, 0, 1, 32'h8000_0014, 1, 32'h2008_0006, 1, 32'h8000_0014, 0, 1, 32'h2008_0005, 32'h8000_0014));
        vecs.push_back(mk(1, 0, 1, 32'h8000_0018, 0, 32'h0,          0, 32'h8000_0014, 1, 1, 32'h2008_0005, 32'h8000_0014));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0018, 0, 32'h0,          0, 32'h8000_0014, 1, 1, 32'h2008_0006, 32'h8000_0018));
        // redirect mid-fetch -> DROP, wrong-path data discarded, refetch from vector
        vecs.push_back(mk(1, 0, 0, 32'h8000_0018, 0, 32'h0,          1, 32'h8000_0018, 1, 0, 32'h0,          32'h8000_0018));
        vecs.push_back(mk(1, 1, 0, 32'h8000_0018, 0, 32'h0,          1, 32'h8000_0018, 0, 0, 32'h0,          32'h8000_0018));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0004, 0, 32'h0,          1, 32'h8000_0018, 1, 0, 32'h0,          32'h8000_0018));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0004, 1, 32'hDEAD_BEEF, 1, 32'h8000_0018, 1, 0, 32'h0,          32'h8000_0018));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0004, 1, 32'h2008_0007, 1, 32'h8000_0004, 0, 1, 32'h2008_0007, 32'h8000_0008));
        // redirect coincident with ack
        vecs.push_back(mk(1, 0, 0, 32'h8000_0008, 0, 32'h0,          1, 32'h8000_0008, 1, 0, 32'h0,          32'h8000_0008));
        vecs.push_back(mk(1, 1, 0, 32'h8000_0008, 1, 32'hBADB_AD01, 1, 32'h8000_0008, 0, 0, 32'h0,          32'h8000_0008));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0100, 1, 32'h2008_0008, 1, 32'h8000_0100, 0, 1, 32'h2008_0008, 32'h8000_0104));
        // redirect while in HOLD
        vecs.push_back(mk(1, 0, 1, 32'h8000_0104, 1, 32'h2008_0009, 1, 32'h8000_0104, 0, 1, 32'h2008_0008, 32'h8000_0104));
        vecs.push_back(mk(1, 1, 1, 32'h8000_0108, 0, 32'h0,          0, 32'h8000_0104, 0, 0, 32'h0,          32'h8000_0104));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0200, 1, 32'h2008_000A, 1, 32'h8000_0200, 0, 1, 32'h2008_000A, 32'h8000_0204));
        // redirect in READY issues no request
        vecs.push_back(mk(1, 1, 0, 32'h8000_0204, 0, 32'h0,          0, 32'h8000_0204, 0, 0, 32'h0,          32'h8000_0204));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0300, 1, 32'h2008_000B, 1, 32'h8000_0300, 0, 1, 32'h2008_000B, 32'h8000_0304));
        // second redirect while in DROP keeps the original request
        vecs.push_back(mk(1, 0, 0, 32'h8000_0304, 0, 32'h0,          1, 32'h8000_0304, 1, 0, 32'h0,          32'h8000_0304));
        vecs.push_back(mk(1, 1, 0, 32'h8000_0304, 0, 32'h0,          1, 32'h8000_0304, 0, 0, 32'h0,          32'h8000_0304));
        vecs.push_back(mk(1, 1, 0, 32'h8000_0400, 0, 32'h0,          1, 32'h8000_0304, 0, 0, 32'h0,          32'h8000_0304));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0500, 1, 32'h0000_FFFF, 1, 32'h8000_0304, 1, 0, 32'h0,          32'h8000_0304));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0500, 1, 32'h2008_000C, 1, 32'h8000_0500, 0, 1, 32'h2008_000C, 32'h8000_0504));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0504, 1, 32'h2008_000D, 1, 32'h8000_0504, 0, 1, 32'h2008_000D, 32'h8000_0508));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].redir, vecs[i].stall, vecs[i].pc, vecs[i].ack, vecs[i].rdata);
            #2;
            chk($sformatf("v%0d.req", i),    {31'h0, imem_bus.req}, {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d.addr", i),   imem_bus.addr,         vecs[i].e_addr);
            chk($sformatf("v%0d.hold", i),   {31'h0, pc_hold},      {31'h0, vecs[i].e_hold});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.valid", i),  {31'h0, ifid_valid},   {31'h0, vecs[i].e_valid});
            chk($sformatf("v%0d.instr", i),  ifid_instr,            vecs[i].e_instr);
            chk($sformatf("v%0d.pcplus", i), ifid_pcplus,           vecs[i].e_pcplus);
            $display("vec %0d: req=%b addr=%h hold=%b ifid=%b/%h/%h", i, imem_bus.req,
                     imem_bus.addr, pc_hold, ifid_valid, ifid_instr, ifid_pcplus);
        end

        // Reset asserted mid-WAIT: outputs revert at once, stale ack is never awaited.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 32'h8000_0508, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 32'h0);
        #1;
        chk("rst.req",    {31'h0, imem_bus.req}, 32'h1);
        chk("rst.addr",   imem_bus.addr,         32'h8000_0000);
        chk("rst.hold",   {31'h0, pc_hold},      32'h1);
        chk("rst.valid",  {31'h0, ifid_valid},   32'h0);
        chk("rst.instr",  ifid_instr,            32'h0);
        chk("rst.pcplus", ifid_pcplus,           32'h0);
        $display("reset mid-wait: req=%b addr=%h ifid=%b/%h/%h", imem_bus.req, imem_bus.addr,
                 ifid_valid, ifid_instr, ifid_pcplus);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 32'h0);
        #2;
        chk("post.addr", imem_bus.addr,    32'h8000_0000);
        chk("post.hold", {31'h0, pc_hold}, 32'h1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 32'h2008_000E);
        #2;
        chk("post.ackhold", {31'h0, pc_hold}, 32'h0);
        @(posedge clk);
        #1;
        chk("post.valid",  {31'h0, ifid_valid}, 32'h1);
        chk("post.instr",  ifid_instr,          32'h2008_000E);
        chk("post.pcplus", ifid_pcplus,         32'h8000_0004);
        $display("post-reset fetch: ifid=%b/%h/%h", ifid_valid, ifid_instr, ifid_pcplus);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage that sits directly downstream of the program counter.
- Takes the current PC and PC+4 and issues a request to a variable-latency instruction memory using a req/ack handshake.
- Loads the returned word into the IF/ID pipeline register.
- Generates pc_hold, which drives the PC's hold/datahazard input.
- Handles ID-stage stalls through a one-entry skid buffer, and handles redirect flushes (branch taken, jump, jr, interrupt/exception) including discarding an in-flight wrong-path fetch.

Parameters:
NOP_INSTR, 32'h00000000, instruction word inserted into IF/ID on bubble/flush
RESET_PC, 32'h80000000, reset value of addr_q; must equal the PC reset vector

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
pc_in  in  32  current PC from the program counter
pcplus_in  in  32  PC+4 from the program counter
redirect  in  1  PC source is not sequential this cycle; flush fetch
id_stall  in  1  ID stage cannot accept a new instruction; IF/ID must hold
imem_req  out  1  instruction memory request
imem_addr  out  32  instruction memory address; stable while imem_req && !imem_ack
imem_ack  in  1  single-cycle completion; imem_rdata is valid in the same cycle
imem_rdata  in  32  instruction word
pc_hold  out  1  to the PC hold input; 1 = PC must not update
ifid_valid  out  1  IF/ID register holds a real instruction
ifid_instr  out  32  IF/ID instruction
ifid_pcplus  out  32  IF/ID PC+4 of that instruction

Behaviour:
- States: READY (no outstanding request), WAIT (request outstanding), HOLD (fetched word parked in skid, ID stalled), DROP (outstanding request abandoned by redirect).
- Reset (async, reset=0):
  - state=READY; addr_q=RESET_PC; pcp_q=0; skid registers cleared.
  - ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pcplus=0.
  - Outputs are combinational from state; a reset asserted mid-WAIT or mid-DROP abandons the request without waiting for its ack.
- imem_req = (READY && !redirect) || WAIT || DROP.
- imem_addr = pc_in in READY; addr_q in WAIT/DROP.
- READY:
  - Always capture addr_q<=pc_in and pcp_q<=pcplus_in.
  - If req is issued and ack arrives the same cycle (zero-wait), this is a completion.
  - If req is issued without ack: go to WAIT.
- WAIT: req held with addr_q; ack is a completion.
- Completion, no redirect:
  - If !id_stall: IF/ID <= {1, rdata, pcplus of the request}; state READY.
  - If id_stall: skid <= {rdata, pcplus}; state HOLD; IF/ID unchanged.
  - pc_hold=0 in the completion cycle, so PC advances exactly once per fetched instruction.
- HOLD: no request; pc_hold=1. When id_stall falls, IF/ID <= skid with valid=1, then state READY.
- DROP: req held with addr_q; on ack the data is discarded and state goes to READY; pc_hold=1 throughout.
- pc_hold = 1 except in a completion cycle, or whenever redirect=1. Redirect always forces pc_hold=0 so the PC loads the target.
- redirect=1 (highest priority, any state, regardless of id_stall):
  - ifid_valid<=0, ifid_instr<=NOP_INSTR.
  - READY: no request issued; stays READY.
  - WAIT without ack: go to DROP.
  - WAIT with ack: data discarded; go to READY.
  - HOLD: skid discarded; go to READY.
  - DROP: stays DROP until ack.
- No completion, no redirect:
  - !id_stall: IF/ID <= bubble (valid=0, NOP_INSTR).
  - id_stall: IF/ID holds.
- Redirect arriving while in DROP does not create a second outstanding request. At most one request is outstanding at any time.
- ifid_pcplus is passed through unmodified, including the kernel bit as supplied by the PC.

Decomposition:
- Shared pipeline package: state encodings (2-bit), NOP_INSTR, RESET_PC.
- No sub-module required. The FSM, the addr/pcplus capture registers, the skid buffer and the IF/ID register live in one module.

Test Plan:
- Zero-wait memory (ack with req), stream of 4 words 0x20080001..0x20080004 from 0x80000000 → one instruction per cycle in IF/ID; ifid_pcplus = 0x80000004, 0x80000008, …; pc_hold low every cycle.
- 3-wait-state memory → imem_addr stable at 0x80000000 for 4 cycles; pc_hold high for 3 cycles then low for 1; IF/ID shows a bubble (valid=0) during the waits, then valid=1 with the word.
- id_stall=1 across the completion cycle → word parked in HOLD; IF/ID unchanged; imem_req=0 and pc_hold=1 while stalled; one cycle after id_stall drops, IF/ID = parked word with valid=1.
- redirect in cycle 2 of a 4-cycle fetch → state DROP; imem_addr held until ack; returned data never appears in IF/ID; next request uses the new pc_in (e.g. 0x80000004 interrupt vector).
- redirect coincident with ack, and redirect while in HOLD → data/skid discarded, ifid_valid=0, next request issued to the redirected PC.
- reset asserted mid-WAIT → all outputs return to reset values immediately; after release the first request goes to 0x80000000 and the stale ack is not awaited.
